note_track_engine: RTL

Generates the four per-lane note occupancy bitmaps (`track0`..`track3`) that the VGA display stage draws. Notes enter at row 0 from a chart-reader handshake, scroll one row toward row ROWS-1 on every scroll tick, and are judged against key presses inside a bottom judgment window. The block produces hit/miss pulses, a saturating score and a combo count for the HUD and audio stages. It sits directly upstream of the display block.

---
 rtl/note_track_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/note_track_engine.sv
`default_nettype none
// ============================================================================
// note_track_engine : four-lane scrolling note bitmaps with hit/miss judging,
//                     saturating score and combo. Optional macro: NOTE_ENGINE_PAUSE_EN
// Revision: 1.0
// ============================================================================
module note_track_engine #(
  parameter int ROWS     = 480,
  parameter int TICK_DIV = 250000,
  parameter int NOTE_LEN = 20,
  parameter int JUDGE_LO = 420,
  parameter int PERF_LO  = 435,
  parameter int PERF_HI  = 455
) (
  input  logic            clk,
  input  logic            rst,
`ifdef NOTE_ENGINE_PAUSE_EN
  input  logic            pause,
`endif
  input  logic            spawn_valid,
  input  logic [3:0]      spawn_lanes,
  output logic            spawn_ready,
  input  logic            key0,
  input  logic            key1,
  input  logic            key2,
  input  logic            key3,
  output logic [ROWS-1:0] track0,
  output logic [ROWS-1:0] track1,
  output logic [ROWS-1:0] track2,
  output logic [ROWS-1:0] track3,
  output logic [3:0]      hit_pulse,
  output logic [3:0]      miss_pulse,
  output logic [15:0]     score,
  output logic [9:0]      combo
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int EW = $clog2(NOTE_LEN + 2);

  localparam logic [TW-1:0]   c_tick_last = TW'(TICK_DIV - 1);
  localparam logic [EW-1:0]   c_emit_full = EW'(NOTE_LEN + 1);
  localparam logic [ROWS-1:0] c_win_mask  = {ROWS{1'b1}} << JUDGE_LO;
  localparam logic [ROWS-1:0] c_perf_mask = ({ROWS{1'b1}} << PERF_LO) &
                                            ({ROWS{1'b1}} >> (ROWS - 1 - PERF_HI));

  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [EW-1:0]   emit_cnt_q [4];
  logic [EW-1:0]   emit_cnt_d [4];
  logic [ROWS-1:0] track_q [4];
  logic [ROWS-1:0] track_d [4];
  logic [3:0]      key_q;
  logic [3:0]      hit_q, hit_d;
  logic [3:0]      miss_q, miss_d;
  logic [15:0]     score_q, score_d;
  logic [9:0]      combo_q, combo_d;

  logic            w_run;
  logic            w_tick;
  logic            w_handshake;
  logic [3:0]      w_keys;
  logic [3:0]      w_perf;
  logic [10:0]     w_pts;
  logic [2:0]      w_nhits;
  logic [16:0]     w_score_sum;
  logic [10:0]     w_combo_sum;

`ifdef NOTE_ENGINE_PAUSE_EN
  assign w_run = ~pause;
`else
  assign w_run = 1'b1;
`endif

  assign w_keys      = {key3, key2, key1, key0};
  assign w_tick      = w_run && (tick_cnt_q == c_tick_last);
  assign spawn_ready = w_run && (emit_cnt_q[0] == '0) && (emit_cnt_q[1] == '0) &&
                       (emit_cnt_q[2] == '0) && (emit_cnt_q[3] == '0);
  assign w_handshake = spawn_valid && spawn_ready;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (w_run) tick_cnt_d = w_tick ? '0 : tick_cnt_q + TW'(1);
  end

  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [ROWS-1:0] w_shift;
    logic            w_edge;

    always_comb begin
      w_shift = track_q[n];
      if (w_tick) w_shift = {track_q[n][ROWS-2:0], (emit_cnt_q[n] > EW'(1))};
    end

    assign w_edge    = w_keys[n] & ~key_q[n] & w_run;
    assign hit_d[n]  = w_edge & (|(track_q[n] & c_win_mask));
    assign w_perf[n] = hit_d[n] & (|(track_q[n] & c_perf_mask));
    // The window clear lands on the already-shifted bitmap.
    assign track_d[n] = hit_d[n] ? (w_shift & ~c_win_mask) : w_shift;
    assign miss_d[n]  = w_tick & track_d[n][ROWS-1] & ~track_q[n][ROWS-1];

    assign emit_cnt_d[n] = (w_handshake && spawn_lanes[n]) ? c_emit_full :
                           (w_tick && (emit_cnt_q[n] != '0)) ? emit_cnt_q[n] - EW'(1) :
                           emit_cnt_q[n];
  end

  always_comb begin
    w_pts   = '0;
    w_nhits = '0;
    for (int n = 0; n < 4; n++) begin
      if (hit_d[n]) begin
        w_nhits = w_nhits + 3'd1;
        w_pts   = w_pts + (w_perf[n] ? 11'd300 : 11'd100);
      end
    end
    w_score_sum = {1'b0, score_q} + {6'd0, w_pts};
    score_d     = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    w_combo_sum = ((|miss_d) ? 11'd0 : {1'b0, combo_q}) + {8'd0, w_nhits};
    combo_d     = (w_combo_sum > 11'd1023) ? 10'h3FF : w_combo_sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      key_q      <= 4'b1111;
      hit_q      <= '0;
      miss_q     <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      for (int n = 0; n < 4; n++) begin
        emit_cnt_q[n] <= '0;
        track_q[n]    <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      key_q      <= w_keys;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      for (int n = 0; n < 4; n++) begin
        emit_cnt_q[n] <= emit_cnt_d[n];
        track_q[n]    <= track_d[n];
      end
    end
  end

  assign track0     = track_q[0];
  assign track1     = track_q[1];
  assign track2     = track_q[2];
  assign track3     = track_q[3];
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign combo      = combo_q;

endmodule
`default_nettype wire
